// File: rtl/dense_mac_sched.sv
// Single dense-layer neuron: bias + sum of N_IN weight*feature terms, one shared 16x16 multiply per cycle.
// Optional macro DENSE_SAT_EN: saturate each term, widen the accumulator, saturate the final result.
module dense_mac_sched #(
  parameter int N_IN = 2,
  parameter int FRAC = 10
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 ap_start,
  input  logic                 input_2_V_ap_vld,
  input  logic [16*N_IN-1:0]   input_2_V,
  input  logic                 cfg_we,
  input  logic [3:0]           cfg_addr,
  input  logic [15:0]          cfg_wdata,
  output logic                 ap_done,
  output logic                 ap_idle,
  output logic                 ap_ready,
  output logic [15:0]          layer7_out_0_V,
  output logic                 layer7_out_0_V_ap_vld
);

  localparam int IDX_W = $clog2(N_IN);
`ifdef DENSE_SAT_EN
  localparam int ACC_W = 16 + $clog2(N_IN + 1);
`else
  localparam int ACC_W = 16;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [15:0]      feat_q [N_IN];
  logic signed [15:0]      feat_d [N_IN];
  logic signed [15:0]      weight_q [N_IN];
  logic signed [15:0]      weight_d [N_IN];
  logic signed [15:0]      bias_q, bias_d;
  logic [15:0]             out_q, out_d;
  logic                    done_q, done_d;
  logic                    ready_q, ready_d;
  logic                    idle_q, idle_d;

  logic signed [15:0]      feat_s;
  logic signed [15:0]      weight_s;
  logic signed [15:0]      term_s;
  logic signed [ACC_W-1:0] acc_sum_s;
  logic [15:0]             result_s;
  logic                    wr_en_s;

  function automatic logic signed [15:0] reset_weight(input int k);
    case (k)
      0:       reset_weight = 16'shFEE0;
      1:       reset_weight = 16'sh0130;
      default: reset_weight = 16'sh0000;
    endcase
  endfunction

`ifdef DENSE_SAT_EN
  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767) begin
      sat16 = 16'sh7FFF;
    end else if (v < -32'sd32768) begin
      sat16 = 16'sh8000;
    end else begin
      sat16 = v[15:0];
    end
  endfunction
`endif

  assign feat_s   = feat_q[idx_q];
  assign weight_s = weight_q[idx_q];

  // Operands are widened to 32 bits so the product is exact before the fixed-point shift.
`ifdef DENSE_SAT_EN
  assign term_s   = sat16((32'(feat_s) * 32'(weight_s)) >>> FRAC);
  assign acc_sum_s = acc_q + ACC_W'(term_s);
  assign result_s = sat16(32'(acc_sum_s));
`else
  assign term_s   = 16'((32'(feat_s) * 32'(weight_s)) >>> FRAC);
  assign acc_sum_s = acc_q + term_s;
  assign result_s = acc_sum_s;
`endif

  assign wr_en_s = cfg_we && (state_q == S_IDLE);

  // Next-state and datapath: coefficient writes land before a coincident accept reads the bias.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    out_d   = out_q;
    feat_d  = feat_q;
    done_d  = 1'b0;
    ready_d = 1'b0;

    for (int k = 0; k < N_IN; k++) begin
      if (wr_en_s && (cfg_addr == 4'(k))) begin
        weight_d[k] = cfg_wdata;
      end else begin
        weight_d[k] = weight_q[k];
      end
    end
    if (wr_en_s && (cfg_addr == 4'(N_IN))) begin
      bias_d = cfg_wdata;
    end else begin
      bias_d = bias_q;
    end

    case (state_q)
      S_IDLE: begin
        if (ap_start && input_2_V_ap_vld) begin
          for (int k = 0; k < N_IN; k++) begin
            feat_d[k] = input_2_V[16*k +: 16];
          end
          acc_d   = ACC_W'(bias_d);
          idx_d   = '0;
          ready_d = 1'b1;
          state_d = S_MAC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MAC: begin
        acc_d = acc_sum_s;
        if (idx_q == IDX_W'(N_IN - 1)) begin
          idx_d   = '0;
          out_d   = result_s;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_MAC;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    idle_d = (state_d == S_IDLE);
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      out_q   <= 16'h0000;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      idle_q  <= 1'b1;
      bias_q  <= 16'sd157;
      for (int k = 0; k < N_IN; k++) begin
        feat_q[k]   <= 16'sh0000;
        weight_q[k] <= reset_weight(k);
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      idle_q   <= idle_d;
      bias_q   <= bias_d;
      feat_q   <= feat_d;
      weight_q <= weight_d;
    end
  end

  assign ap_done               = done_q;
  assign ap_ready              = ready_q;
  assign ap_idle               = idle_q;
  assign layer7_out_0_V        = out_q;
  assign layer7_out_0_V_ap_vld = done_q;

endmodule

// File: tb/tb_dense_mac_sched.sv
// Self-checking bench for dense_mac_sched: directed cases plus randomized traffic against a timeline model.
module tb_dense_mac_sched;

  localparam int N    = 2;
  localparam int FRAC = 10;

  logic            ap_clk;
  logic            ap_rst = 1'b1;
  logic            ap_start = 1'b0;
  logic            input_2_V_ap_vld = 1'b0;
  logic [16*N-1:0] input_2_V = '0;
  logic            cfg_we = 1'b0;
  logic [3:0]      cfg_addr = 4'd0;
  logic [15:0]     cfg_wdata = 16'd0;
  logic            ap_done, ap_idle, ap_ready, out_vld;
  logic [15:0]     out_v;

  int checks = 0;
  int errors = 0;

  dense_mac_sched #(.N_IN(N), .FRAC(FRAC)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .input_2_V_ap_vld(input_2_V_ap_vld), .input_2_V(input_2_V),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .layer7_out_0_V(out_v), .layer7_out_0_V_ap_vld(out_vld)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: coefficients, cycles since accept, and the expected outputs.
  logic [15:0] m_w [N];
  logic [15:0] m_bias;
  int          m_phase;
  logic [15:0] m_pending;
  logic        exp_done, exp_ready, exp_idle;
  logic [15:0] exp_out;

  function automatic logic [15:0] neuron(input logic [16*N-1:0] x);
    longint sum, t;
    sum = longint'($signed(m_bias));
    for (int k = 0; k < N; k++) begin
      t = longint'($signed(x[16*k +: 16])) * longint'($signed(m_w[k]));
      t = t >>> FRAC;
`ifdef DENSE_SAT_EN
      if (t > 32767) t = 32767;
      else if (t < -32768) t = -32768;
`endif
      sum = sum + t;
    end
`ifdef DENSE_SAT_EN
    if (sum > 32767) sum = 32767;
    else if (sum < -32768) sum = -32768;
`endif
    return sum[15:0];
  endfunction

  task automatic reset_model();
    m_w[0] = 16'hFEE0;
    m_w[1] = 16'h0130;
    for (int k = 2; k < N; k++) m_w[k] = 16'h0000;
    m_bias    = 16'd157;
    m_phase   = -1;
    m_pending = 16'd0;
    exp_done  = 1'b0;
    exp_ready = 1'b0;
    exp_idle  = 1'b1;
    exp_out   = 16'd0;
  endtask

  task automatic step_model();
    exp_done  = 1'b0;
    exp_ready = 1'b0;
    if (m_phase < 0) begin
      if (cfg_we) begin
        if (cfg_addr < 4'(N)) m_w[cfg_addr] = cfg_wdata;
        else if (cfg_addr == 4'(N)) m_bias = cfg_wdata;
      end
      if (ap_start && input_2_V_ap_vld) begin
        m_pending = neuron(input_2_V);
        m_phase   = 1;
        exp_ready = 1'b1;
        exp_idle  = 1'b0;
      end
    end else begin
      m_phase++;
      if (m_phase == N + 2) begin
        m_phase  = -1;
        exp_idle = 1'b1;
      end else if (m_phase == N + 1) begin
        exp_done = 1'b1;
        exp_out  = m_pending;
      end
    end
  endtask

  initial begin
    reset_model();
    forever begin
      @(posedge ap_clk or posedge ap_rst);
      if (ap_rst) reset_model();
      else step_model();
    end
  end

  // Every falling edge: all DUT outputs against the model.
  always @(negedge ap_clk) begin
    chk("cmp_done", ap_done, exp_done);
    chk("cmp_vld", out_vld, exp_done);
    chk("cmp_ready", ap_ready, exp_ready);
    chk("cmp_idle", ap_idle, exp_idle);
    chk("cmp_out", out_v, exp_out);
  end

  task automatic run_vec(input logic [15:0] f0, input logic [15:0] f1,
                         input logic [15:0] lit, input bit mid_write, input string nm);
    int n;
    bit seen;
    ap_start = 1'b1;
    input_2_V_ap_vld = 1'b1;
    input_2_V = {f1, f0};
    @(negedge ap_clk);
    ap_start = 1'b0;
    input_2_V_ap_vld = 1'b0;
    chk({nm, "_ready"}, ap_ready, 1);
    if (mid_write) begin
      cfg_we = 1'b1;
      cfg_addr = 4'(N);
      cfg_wdata = 16'd1000;
    end
    seen = 1'b0;
    n = 1;
    while (!seen && n < 20) begin
      @(negedge ap_clk);
      n++;
      cfg_we = 1'b0;
      if (ap_done) seen = 1'b1;
    end
    chk({nm, "_latency"}, n, N + 1);
    chk({nm, "_out"}, out_v, lit);
    @(negedge ap_clk);
  endtask

  initial begin
    int prev_rdy;
    bit prev_done;
    @(negedge ap_clk);
    chk("rst_idle", ap_idle, 1);
    chk("rst_out", out_v, 0);
    chk("rst_ready", ap_ready, 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    chk("pin_model_a", neuron({16'd1024, 16'd1024}), 173);
    chk("pin_model_b", neuron({16'd0, 16'hFC00}), 445);
    @(negedge ap_clk);

    run_vec(16'd1024, 16'd1024, 16'd173, 1'b0, "basic");
    run_vec(16'hFC00, 16'd0, 16'd445, 1'b0, "negfeat");

    // ap_start without valid data must not be accepted.
    ap_start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge ap_clk);
      chk("novld_idle", ap_idle, 1);
      chk("novld_ready", ap_ready, 0);
    end
    ap_start = 1'b0;

    run_vec(16'd1024, 16'd1024, 16'd173, 1'b1, "busywr");
    run_vec(16'd1024, 16'd1024, 16'd173, 1'b0, "busywr_after");

    // Back-to-back accepts with start and valid held high.
    ap_start = 1'b1;
    input_2_V_ap_vld = 1'b1;
    prev_rdy = -1;
    prev_done = 1'b0;
    for (int c = 0; c < 6 * (N + 2); c++) begin
      for (int k = 0; k < N; k++) input_2_V[16*k +: 16] = 16'($urandom);
      @(negedge ap_clk);
      if (ap_ready) begin
        if (prev_rdy >= 0) chk("b2b_period", c - prev_rdy, N + 2);
        prev_rdy = c;
      end
      if (ap_done) chk("b2b_done_pulse", prev_done, 0);
      prev_done = ap_done;
    end
    ap_start = 1'b0;
    input_2_V_ap_vld = 1'b0;
    repeat (N + 3) @(negedge ap_clk);

    // Saturation / wrap corner.
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 16'h7FFF;
    @(negedge ap_clk);
    cfg_addr = 4'd1;
    @(negedge ap_clk);
    cfg_we = 1'b0;
`ifdef DENSE_SAT_EN
    run_vec(16'h7FFF, 16'h7FFF, 16'd32767, 1'b0, "bigprod");
`else
    run_vec(16'h7FFF, 16'h7FFF, 16'd29, 1'b0, "bigprod");
`endif

    // Reset in the middle of the MAC phase.
    cfg_we = 1'b1; cfg_addr = 4'(N); cfg_wdata = 16'd500;
    ap_start = 1'b1; input_2_V_ap_vld = 1'b1; input_2_V = {16'd1024, 16'd1024};
    @(negedge ap_clk);
    cfg_we = 1'b0; ap_start = 1'b0; input_2_V_ap_vld = 1'b0;
    @(negedge ap_clk);
    #2 ap_rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge ap_clk);
      chk("midrst_done", ap_done, 0);
      chk("midrst_vld", out_vld, 0);
      chk("midrst_idle", ap_idle, 1);
      chk("midrst_out", out_v, 0);
    end
    ap_rst = 1'b0;
    @(negedge ap_clk);
    run_vec(16'd0, 16'd0, 16'd157, 1'b0, "bias_restored");
    run_vec(16'd1024, 16'd1024, 16'd173, 1'b0, "weights_restored");

    // Randomized traffic, including writes to out-of-range addresses and rare resets.
    for (int c = 0; c < 800; c++) begin
      ap_start = 1'($urandom_range(0, 1));
      input_2_V_ap_vld = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) input_2_V[16*k +: 16] = 16'($urandom);
      cfg_we = ($urandom_range(0, 3) == 0);
      cfg_addr = 4'($urandom_range(0, N + 3));
      cfg_wdata = 16'($urandom);
      if ($urandom_range(0, 199) == 0) #2 ap_rst = 1'b1;
      @(negedge ap_clk);
      ap_rst = 1'b0;
    end
    ap_start = 1'b0;
    input_2_V_ap_vld = 1'b0;
    cfg_we = 1'b0;
    repeat (N + 3) @(negedge ap_clk);

    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dense_mac_sched.md
DENSE_MAC_SCHED -- requirements
Module: dense_mac_sched

Interface
REQ-001 SHALL have parameter N_IN, default 2: number of 16-bit features per input word; legal range 2..8.
REQ-002 SHALL have parameter FRAC, default 10: fractional bits of weights and features.
REQ-003 SHALL have port ap_clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port ap_rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port ap_start, input, 1: request to process one input vector.
REQ-006 SHALL have port input_2_V_ap_vld, input, 1: input_2_V holds valid data.
REQ-007 SHALL have port input_2_V, input, 16*N_IN: packed signed features; feature k occupies bits [16k+15:16k].
REQ-008 SHALL have port cfg_we, input, 1: coefficient write strobe.
REQ-009 SHALL have port cfg_addr, input, 4: addresses 0..N_IN-1 select weight k; address N_IN selects the bias.
REQ-010 SHALL have port cfg_wdata, input, 16: signed coefficient value.
REQ-011 SHALL have port ap_done, output, 1: one-cycle pulse marking a result.
REQ-012 SHALL have port ap_idle, output, 1: high while the FSM is in IDLE.
REQ-013 SHALL have port ap_ready, output, 1: one-cycle pulse; the input has been consumed.
REQ-014 SHALL have port layer7_out_0_V, output, 16: signed neuron result.
REQ-015 SHALL have port layer7_out_0_V_ap_vld, output, 1: equals ap_done.

Function
REQ-016 SHALL use a 3-state FSM: IDLE, MAC, DONE.
REQ-017 SHALL, in IDLE, accept on an edge where ap_start=1 and input_2_V_ap_vld=1: latch input_2_V, load the accumulator with the bias, set index=0, go to MAC.
REQ-018 SHALL stay in IDLE when ap_start=1 with input_2_V_ap_vld=0.
REQ-019 SHALL assert ap_ready for exactly one cycle, in the cycle after the accept edge.
REQ-020 SHALL, in MAC, use one shared signed 16x16 multiplier to process one feature per cycle (index 0..N_IN-1), then go to DONE after index N_IN-1.
REQ-021 SHALL form each term as product bits [FRAC+15:FRAC] (arithmetic floor) and add it to a 16-bit accumulator with two's-complement wrap.
REQ-022 SHALL, in DONE, drive layer7_out_0_V=accumulator and assert ap_done and layer7_out_0_V_ap_vld for one cycle, then return to IDLE.
REQ-023 SHALL give a latency of N_IN+1 cycles: accept edge at cycle T, result valid during cycle T+N_IN+1.
REQ-024 SHALL hold layer7_out_0_V at the last result between results.
REQ-025 SHALL ignore ap_start in MAC and DONE; a new accept is possible no earlier than the edge that ends DONE.
REQ-026 SHALL apply cfg_we writes only when ap_idle=1, SHALL ignore writes in other states, and SHALL ignore cfg_addr>N_IN.
REQ-027 SHALL apply the earlier write and perform the accept when a write and an accept coincide on the same edge; the new value SHALL be used by that operation.

Reset
REQ-028 SHALL, on ap_rst, immediately force: state=IDLE, ap_idle=1, ap_done=0, ap_ready=0, layer7_out_0_V_ap_vld=0, layer7_out_0_V=0, index=0, accumulator=0.
REQ-029 SHALL, on ap_rst, restore coefficients to weight0=0xFEE0 (-288), weight1=0x0130 (304), weights 2+ =0, and bias=157.
REQ-030 SHALL, when ap_rst asserts mid-MAC, abort the operation with no ap_done pulse.

Configuration
REQ-031 SHALL support macro DENSE_SAT_EN.
- Defined: each term is saturated to [-32768, 32767] before accumulation; the accumulator widens to 16+clog2(N_IN+1) bits; the final result is saturated to 16 bits.
- Undefined: wrap behaviour exactly as in REQ-021.

Verification
REQ-032 SHALL cover, with reset coefficients and N_IN=2: features (1024, 1024) -> layer7_out_0_V=173, with ap_done at T+3 and ap_ready at T+1.
REQ-033 SHALL cover: features (0xFC00, 0) -> result 445.
REQ-034 SHALL cover: write weight0=weight1=0x7FFF, then features (0x7FFF, 0x7FFF) -> result 29 without DENSE_SAT_EN and 32767 with it.
REQ-035 SHALL cover: ap_start=1 with input_2_V_ap_vld=0 for 5 cycles -> ap_idle stays 1 and there is no ap_ready; also a cfg_we write to bias while in MAC -> ignored and the next result is unchanged.
REQ-036 SHALL cover: ap_rst asserted during MAC cycle 1 -> no ap_done, all outputs at reset values, bias back to 157.
REQ-037 SHALL cover: back-to-back ap_start held high with vld high -> accepts every N_IN+2 cycles, with each ap_done pulse exactly one cycle.
